// File: rtl/conv_pkg.sv
// Shared definitions for the convolution result path: FSM encoding, pixel width
// and default frame geometry.
package conv_pkg;

    localparam int PIX_W      = 8;
    localparam int IMG_W_DEF  = 256;
    localparam int IMG_H_DEF  = 256;
    localparam int IMG_PIXELS = IMG_W_DEF * IMG_H_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/wr_fifo.sv
// Small synchronous FIFO with a first-word-fall-through head; push and pop on the
// same edge are legal at any occupancy the caller allows (full with pop, one entry).
module wr_fifo
    import conv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [PIX_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // At full the write slot equals the head slot; the head is read out before
    // the edge overwrites it, so push-with-pop at full is safe.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/conv_result_writer.sv
// Writes the filter's raster-order result stream into the result SRAM through a
// small FIFO. Optional running checksum of written data: define WR_CHECKSUM_EN.
module conv_result_writer
    import conv_pkg::*;
#(
    parameter int                IMG_W      = IMG_W_DEF,
    parameter int                IMG_H      = IMG_H_DEF,
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [PIX_W-1:0]  in_pixel,
    input  logic              grant,
    output logic [ADDR_W-1:0] addr,
    output logic              wen,
    output logic [PIX_W-1:0]  d,
    output logic              done,
    output logic              overflow
`ifdef WR_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    localparam logic [ADDR_W:0] FRAME_CNT = (ADDR_W+1)'(IMG_W * IMG_H);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W:0]   wcnt;
    logic              arm;
    logic              push;
    logic              pop;
    logic              drop;
    logic              full;
    logic              empty;
    logic [PIX_W-1:0]  head;

    wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (arm),
        .push  (push),
        .pop   (pop),
        .din   (in_pixel),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        arm     = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        drop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    arm     = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                pop  = grant && !empty;
                push = in_valid && (!full || pop);
                drop = in_valid && full && !pop;
                if (pop && (wcnt == FRAME_CNT - 1'b1)) state_d = DONE;
            end
            DONE: begin
                drop = in_valid;
                if (start) begin
                    arm     = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // done lags the state by one edge so it rises after the last write cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr     <= BASE_ADDR;
            wen      <= 1'b1;
            d        <= '0;
            wcnt     <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wen <= 1'b1;
            d   <= '0;
            if (pop) begin
                wen  <= 1'b0;
                d    <= head;
                addr <= BASE_ADDR + wcnt[ADDR_W-1:0];
                wcnt <= wcnt + 1'b1;
            end
            if (arm) begin
                wcnt     <= '0;
                done     <= 1'b0;
                overflow <= 1'b0;
            end else begin
                done <= (state_q == DONE);
                if (drop) overflow <= 1'b1;
            end
        end
    end

`ifdef WR_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst_n || arm) checksum <= '0;
        else if (pop)      checksum <= checksum + 16'(head);
    end
`endif

endmodule

// File: tb/tb_conv_result_writer.sv
// Scoreboard bench for conv_result_writer on a 4x2 frame at base 0x100; the
// checksum section runs only when WR_CHECKSUM_EN is defined.
module tb_conv_result_writer;

    localparam int                ADDR_W = 16;
    localparam logic [ADDR_W-1:0] BASE   = 16'h0100;
    localparam int                W      = ADDR_W + 8;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_pixel;
    logic              grant;
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [7:0]        d;
    logic              done;
    logic              overflow;
`ifdef WR_CHECKSUM_EN
    logic [15:0]       checksum;
`endif

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    conv_result_writer #(
        .IMG_W      (4),
        .IMG_H      (2),
        .ADDR_W     (ADDR_W),
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_pixel (in_pixel),
        .grant    (grant),
        .addr     (addr),
        .wen      (wen),
        .d        (d),
        .done     (done),
        .overflow (overflow)
`ifdef WR_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard monitor: every write the DUT presents must match the queue head
    always @(posedge clk) begin
        logic [W-1:0] exp_v;
        #1;
        if (wen === 1'b0) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%h d=%h, required no write", addr, d);
            end else begin
                exp_v = exp_q.pop_front();
                if ({addr, d} !== exp_v) begin
                    n_fail++;
                    $display("FAIL write: got addr=%h d=%h, required addr=%h d=%h",
                             addr, d, exp_v[W-1:8], exp_v[7:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // driver: called at a falling edge, applies inputs for one rising edge,
    // returns at the next falling edge
    task automatic drive(input logic v, input logic [7:0] p, input logic g, input logic s);
        in_valid = v;
        in_pixel = p;
        grant    = g;
        start    = s;
        @(negedge clk);
    endtask

    task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [7:0] p);
        exp_q.push_back({a, p});
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_pixel = '0; grant = 1'b0;
        @(negedge clk);
        drive(0, 8'h00, 0, 0);
        drive(0, 8'h00, 0, 0);
        rst_n = 1'b1;
        check("rst_wen", 32'(wen), 32'h1);
        check("rst_addr", 32'(addr), 32'h100);
        check("rst_d", 32'(d), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);

        // stream with grant high, start ignored in RUN, done timing
        drive(0, 8'h00, 1, 1);
        for (int i = 0; i < 4; i++) begin
            expect_write(BASE + 16'(i), 8'(8'h10 * (i + 1)));
            drive(1, 8'(8'h10 * (i + 1)), 1, 0);
        end
        drive(0, 8'h00, 1, 0);
        drive(0, 8'h00, 1, 0);
        drive(0, 8'h00, 1, 0);
        check("t1_overflow", 32'(overflow), 32'h0);
        check("t1_drained", 32'(exp_q.size()), 32'h0);
        drive(0, 8'h00, 1, 1);
        for (int i = 0; i < 4; i++) begin
            expect_write(BASE + 16'(4 + i), 8'(8'h50 + 8'h10 * i));
            drive(1, 8'(8'h50 + 8'h10 * i), 1, 0);
        end
        drive(0, 8'h00, 1, 0);
        check("t1_done_during_last_write", 32'(done), 32'h0);
        drive(0, 8'h00, 1, 0);
        check("t1_done_after_last_write", 32'(done), 32'h1);
        check("t1_wen_in_done", 32'(wen), 32'h1);
        drive(1, 8'h99, 1, 0);
        check("t1_overflow_in_done", 32'(overflow), 32'h1);
        drive(0, 8'h00, 1, 0);
        drive(0, 8'h00, 1, 0);
        check("t1_done_held", 32'(done), 32'h1);

        // re-arm from DONE, stall with full FIFO, then toggling grant
        drive(0, 8'h00, 0, 1);
        check("t2_done_cleared", 32'(done), 32'h0);
        check("t2_overflow_cleared", 32'(overflow), 32'h0);
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) expect_write(BASE + 16'(i - 1), 8'(i));
            drive(1, 8'(i), 0, 0);
            if (i == 4) check("t2_overflow_at_full", 32'(overflow), 32'h0);
        end
        check("t2_overflow_dropped", 32'(overflow), 32'h1);
        for (int i = 0; i < 6; i++) drive(0, 8'h00, 1, 0);
        check("t2_drained", 32'(exp_q.size()), 32'h0);
        for (int i = 0; i < 4; i++) begin
            expect_write(BASE + 16'(4 + i), 8'(6 + i));
            drive(1, 8'(6 + i), (i % 2 == 0), 0);
        end
        for (int j = 0; j < 12 && !done; j++) drive(0, 8'h00, (j % 2 == 0), 0);
        check("t2_done", 32'(done), 32'h1);
        check("t2_all_written", 32'(exp_q.size()), 32'h0);

        // reset mid-frame with pixels still queued
        drive(0, 8'h00, 1, 1);
        for (int i = 0; i < 3; i++) begin
            expect_write(BASE + 16'(i), 8'(8'hC1 + i));
            drive(1, 8'(8'hC1 + i), 1, 0);
        end
        drive(0, 8'h00, 1, 0);
        drive(0, 8'h00, 1, 0);
        drive(0, 8'h00, 1, 0);
        check("t3_drained", 32'(exp_q.size()), 32'h0);
        drive(1, 8'h5A, 0, 0);
        drive(1, 8'h5B, 0, 0);
        rst_n = 1'b0;
        drive(0, 8'h00, 0, 0);
        rst_n = 1'b1;
        check("t3_rst_wen", 32'(wen), 32'h1);
        check("t3_rst_addr", 32'(addr), 32'h100);
        check("t3_rst_done", 32'(done), 32'h0);
        check("t3_rst_overflow", 32'(overflow), 32'h0);
        drive(0, 8'h00, 1, 0);
        drive(0, 8'h00, 1, 1);
        expect_write(BASE, 8'hAA);
        drive(1, 8'hAA, 1, 0);
        drive(0, 8'h00, 1, 0);
        drive(0, 8'h00, 1, 0);
        drive(0, 8'h00, 1, 0);
        check("t3_after_reset_write", 32'(exp_q.size()), 32'h0);

`ifdef WR_CHECKSUM_EN
        rst_n = 1'b0;
        drive(0, 8'h00, 0, 0);
        rst_n = 1'b1;
        check("cs_reset", 32'(checksum), 32'h0);
        drive(0, 8'h00, 1, 1);
        expect_write(BASE + 16'd0, 8'd255);
        drive(1, 8'd255, 1, 0);
        expect_write(BASE + 16'd1, 8'd255);
        drive(1, 8'd255, 1, 0);
        expect_write(BASE + 16'd2, 8'd2);
        drive(1, 8'd2, 1, 0);
        drive(0, 8'h00, 1, 0);
        drive(0, 8'h00, 1, 0);
        check("cs_three", 32'(checksum), 32'h0200);
        for (int i = 0; i < 4; i++) begin
            expect_write(BASE + 16'(3 + i), 8'd1);
            drive(1, 8'd1, 0, 0);
        end
        drive(1, 8'd7, 0, 0);
        check("cs_overflow", 32'(overflow), 32'h1);
        for (int i = 0; i < 6; i++) drive(0, 8'h00, 1, 0);
        expect_write(BASE + 16'd7, 8'd3);
        drive(1, 8'd3, 1, 0);
        drive(0, 8'h00, 1, 0);
        drive(0, 8'h00, 1, 0);
        drive(0, 8'h00, 1, 0);
        check("cs_done", 32'(done), 32'h1);
        check("cs_final", 32'(checksum), 32'h0207);
`endif

        check("final_queue_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
